// File: rtl/memory_port.sv
// CPU-side memory access stage: turns byte/half/word/dword requests into
// word-wide accesses on a big-endian byte-lane memory (bit 0 = MSB).
module memory_port #(
   parameter bit ALIGN_CHECK = 1'b1,
   localparam int unsigned AW  = 17,
   localparam int unsigned BW  = 19,
   localparam int unsigned DW  = 32,
   localparam int unsigned RW  = 64,
   localparam int unsigned LW  = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [0:1]    req_size,
   input  logic [0:BW-1] req_addr,
   input  logic [0:RW-1] req_wdata,
   output logic          rsp_valid,
   output logic          rsp_error,
   output logic [0:RW-1] rsp_rdata,
   output logic [0:AW-1] mem_address,
   output logic [0:LW-1] mem_write_en,
   output logic [0:DW-1] mem_data_out,
   input  logic [0:DW-1] mem_data_in
);

   localparam logic [0:1] SZ_BYTE  = 2'd0;
   localparam logic [0:1] SZ_HALF  = 2'd1;
   localparam logic [0:1] SZ_WORD  = 2'd2;
   localparam logic [0:1] SZ_DWORD = 2'd3;

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   state_t        state, state_nxt;
   logic          write_q, write_nxt;
   logic [0:1]    size_q, size_nxt;
   logic [0:BW-1] addr_q, addr_nxt;
   logic [0:DW-1] wdata_q, wdata_nxt;
   logic          ready_nxt, valid_nxt, error_nxt;
   logic [0:RW-1] rdata_nxt;
   logic [0:AW-1] maddr_nxt;
   logic [0:LW-1] wen_nxt;
   logic [0:DW-1] mdata_nxt;

   logic          misaligned;
   logic [0:BW-1] addr_m;
   logic [0:LW-1] wen_req;
   logic [0:DW-1] wdat_req;
   logic [0:7]    lane_byte;
   logic [0:15]   lane_half;
   logic [0:RW-1] rd_ext;

   // Alignment check and low-bit masking of the incoming address
   always_comb begin
      addr_m     = req_addr;
      misaligned = 1'b0;
      case (req_size)
         SZ_HALF: begin
            misaligned = req_addr[18];
            addr_m[18] = 1'b0;
         end
         SZ_WORD: begin
            misaligned    = |req_addr[17:18];
            addr_m[17:18] = 2'b00;
         end
         SZ_DWORD: begin
            misaligned    = |req_addr[16:18];
            addr_m[16:18] = 3'b000;
         end
         default: ;
      endcase
   end

   // First-access lane enables and replicated write data from the request
   always_comb begin
      wen_req  = '0;
      wdat_req = '0;
      case (req_size)
         SZ_BYTE: begin
            wdat_req = {4{req_wdata[56:63]}};
            case (addr_m[17:18])
               2'd0:    wen_req = 4'b1000;
               2'd1:    wen_req = 4'b0100;
               2'd2:    wen_req = 4'b0010;
               default: wen_req = 4'b0001;
            endcase
         end
         SZ_HALF: begin
            wdat_req = {2{req_wdata[48:63]}};
            wen_req  = addr_m[17] ? 4'b0011 : 4'b1100;
         end
         SZ_WORD: begin
            wdat_req = req_wdata[32:63];
            wen_req  = '1;
         end
         default: begin
            wdat_req = req_wdata[0:31];
            wen_req  = '1;
         end
      endcase
   end

   // Right-justify the first memory word according to the latched size/lane
   always_comb begin
      lane_byte = '0;
      lane_half = addr_q[17] ? mem_data_in[16:31] : mem_data_in[0:15];
      rd_ext    = rsp_rdata;
      case (addr_q[17:18])
         2'd0:    lane_byte = mem_data_in[0:7];
         2'd1:    lane_byte = mem_data_in[8:15];
         2'd2:    lane_byte = mem_data_in[16:23];
         default: lane_byte = mem_data_in[24:31];
      endcase
      case (size_q)
         SZ_BYTE:  rd_ext = {56'd0, lane_byte};
         SZ_HALF:  rd_ext = {{48{lane_half[0]}}, lane_half};
         SZ_WORD:  rd_ext = {32'd0, mem_data_in};
         default:  rd_ext[0:31] = mem_data_in;
      endcase
   end

   // Next state and next registered outputs
   always_comb begin
      state_nxt = state;
      write_nxt = write_q;
      size_nxt  = size_q;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      valid_nxt = 1'b0;
      error_nxt = rsp_error;
      rdata_nxt = rsp_rdata;
      maddr_nxt = mem_address;
      wen_nxt   = '0;
      mdata_nxt = mem_data_out;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               write_nxt = req_write;
               size_nxt  = req_size;
               addr_nxt  = addr_m;
               wdata_nxt = req_wdata[32:63];
               if (ALIGN_CHECK && misaligned) begin
                  state_nxt = RESP;
                  valid_nxt = 1'b1;
                  error_nxt = 1'b1;
                  rdata_nxt = '0;
               end else begin
                  state_nxt = ACC0;
                  error_nxt = 1'b0;
                  maddr_nxt = addr_m[0:16];
                  if (req_write) begin
                     wen_nxt   = wen_req;
                     mdata_nxt = wdat_req;
                  end
               end
            end
         end
         ACC0: begin
            if (!write_q) rdata_nxt = rd_ext;
            if (size_q == SZ_DWORD) begin
               state_nxt = ACC1;
               maddr_nxt = addr_q[0:16] + AW'(1);
               if (write_q) begin
                  wen_nxt   = '1;
                  mdata_nxt = wdata_q;
               end
            end else begin
               state_nxt = RESP;
               valid_nxt = 1'b1;
            end
         end
         ACC1: begin
            if (!write_q) rdata_nxt[32:63] = mem_data_in;
            state_nxt = RESP;
            valid_nxt = 1'b1;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      ready_nxt = (state_nxt == IDLE);
   end

   // State, latched request and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         write_q      <= 1'b0;
         size_q       <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_error    <= 1'b0;
         rsp_rdata    <= '0;
         mem_address  <= '0;
         mem_write_en <= '0;
         mem_data_out <= '0;
      end else begin
         state        <= state_nxt;
         write_q      <= write_nxt;
         size_q       <= size_nxt;
         addr_q       <= addr_nxt;
         wdata_q      <= wdata_nxt;
         req_ready    <= ready_nxt;
         rsp_valid    <= valid_nxt;
         rsp_error    <= error_nxt;
         rsp_rdata    <= rdata_nxt;
         mem_address  <= maddr_nxt;
         mem_write_en <= wen_nxt;
         mem_data_out <= mdata_nxt;
      end
   end

endmodule

// File: tb/tb_memory_port.sv
// Directed bench for memory_port: one checked instance with alignment
// checking, one with it disabled, and a byte-lane memory model.
module tb_memory_port;

   logic        clock = 1'b0;
   logic        reset = 1'b0;

   logic        req_valid = 1'b0, req_write = 1'b0;
   logic [0:1]  req_size = 2'd0;
   logic [0:18] req_addr = '0;
   logic [0:63] req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_error;
   logic [0:63] rsp_rdata;
   logic [0:16] mem_address;
   logic [0:3]  mem_write_en;
   logic [0:31] mem_data_out, mem_data_in;

   logic        n_req_valid = 1'b0, n_req_write = 1'b0;
   logic [0:1]  n_req_size = 2'd0;
   logic [0:18] n_req_addr = '0;
   logic [0:63] n_req_wdata = '0;
   logic        n_req_ready, n_rsp_valid, n_rsp_error;
   logic [0:63] n_rsp_rdata;
   logic [0:16] n_mem_address;
   logic [0:3]  n_mem_write_en;
   logic [0:31] n_mem_data_out, n_mem_data_in;

   logic [0:31] mem [0:131071];

   int          errors = 0;
   int          checks = 0;
   int          t_lat;
   logic [0:63] t_rd;
   logic        t_er;
   logic [0:16] a0_addr, a1_addr;
   logic [0:3]  a0_wen, a1_wen;
   logic [0:31] a0_data, a1_data;
   logic        wen_seen = 1'b0;

   memory_port #(.ALIGN_CHECK(1'b1)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
      .mem_address(mem_address), .mem_write_en(mem_write_en),
      .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
   );

   memory_port #(.ALIGN_CHECK(1'b0)) dut_n (
      .clock(clock), .reset(reset),
      .req_valid(n_req_valid), .req_ready(n_req_ready), .req_write(n_req_write),
      .req_size(n_req_size), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
      .rsp_valid(n_rsp_valid), .rsp_error(n_rsp_error), .rsp_rdata(n_rsp_rdata),
      .mem_address(n_mem_address), .mem_write_en(n_mem_write_en),
      .mem_data_out(n_mem_data_out), .mem_data_in(n_mem_data_in)
   );

   always #5 clock = ~clock;

   // Byte-lane memory: combinational read, per-lane synchronous write
   assign mem_data_in = mem[mem_address];
   always @(posedge clock) begin
      for (int i = 0; i < 4; i++)
         if (mem_write_en[i]) mem[mem_address][8*i +: 8] <= mem_data_out[8*i +: 8];
   end

   // Fixed read-only image for the unchecked instance
   assign n_mem_data_in = (n_mem_address == 17'h00005) ? 32'h89ABCDEF : 32'h0;

   always @(mem_write_en) if (mem_write_en != 4'b0000) wen_seen = 1'b1;

   // One transaction on the checked instance; records latency and access cycles
   task automatic xact(input logic w, input logic [0:1] sz, input logic [0:18] a,
                       input logic [0:63] wd);
      int waits;
      @(negedge clock);
      req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
      waits = 0;
      while (!req_ready && waits < 20) begin @(negedge clock); waits++; end
      @(posedge clock); #1;
      req_valid = 1'b0;
      t_lat = 1;
      a0_addr = mem_address; a0_wen = mem_write_en; a0_data = mem_data_out;
      while (!rsp_valid && t_lat < 10) begin
         @(posedge clock); #1;
         t_lat++;
         if (t_lat == 2) begin
            a1_addr = mem_address; a1_wen = mem_write_en; a1_data = mem_data_out;
         end
      end
      if (!rsp_valid || waits >= 20) t_lat = -1;
      t_rd = rsp_rdata;
      t_er = rsp_error;
   endtask

   // One transaction on the unchecked instance
   task automatic n_xact(input logic w, input logic [0:1] sz, input logic [0:18] a);
      int waits;
      @(negedge clock);
      n_req_valid = 1'b1; n_req_write = w; n_req_size = sz; n_req_addr = a;
      waits = 0;
      while (!n_req_ready && waits < 20) begin @(negedge clock); waits++; end
      @(posedge clock); #1;
      n_req_valid = 1'b0;
      t_lat = 1;
      a0_addr = n_mem_address;
      while (!n_rsp_valid && t_lat < 10) begin @(posedge clock); #1; t_lat++; end
      if (!n_rsp_valid || waits >= 20) t_lat = -1;
      t_rd = n_rsp_rdata;
      t_er = n_rsp_error;
   endtask

   task automatic test_reset;
      int waits;
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 19'h00014;
      repeat (3) begin
         @(negedge clock);
         checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
         checks++; if (mem_write_en !== 4'b0000) begin errors++; $display("FAIL reset_wen: got %b want 0000", mem_write_en); end
         checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      end
      checks++; if (rsp_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
      checks++; if (mem_address !== 17'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_address); end
      checks++; if (mem_data_out !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_data_out); end
      checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", rsp_error); end
      reset = 1'b1;
      @(posedge clock); #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_first_accept: ready got %b want 0", req_ready); end
      req_valid = 1'b0;
      waits = 0;
      while (!rsp_valid && waits < 10) begin @(posedge clock); #1; waits++; end
      checks++; if (waits !== 1) begin errors++; $display("FAIL reset_first_rsp: extra edges got %0d want 1", waits); end
   endtask

   task automatic test_word;
      xact(1'b1, 2'd2, 19'h00014, 64'h0000_0000_89AB_CDEF);
      checks++; if (t_lat !== 2) begin errors++; $display("FAIL word_wr_lat: got %0d want 2", t_lat); end
      checks++; if (a0_wen !== 4'b1111) begin errors++; $display("FAIL word_wr_wen: got %b want 1111", a0_wen); end
      checks++; if (a0_data !== 32'h89ABCDEF) begin errors++; $display("FAIL word_wr_data: got %h want 89abcdef", a0_data); end
      xact(1'b0, 2'd2, 19'h00014, 64'h0);
      checks++; if (a0_addr !== 17'h00005) begin errors++; $display("FAIL word_rd_addr: got %h want 00005", a0_addr); end
      checks++; if (t_lat !== 2) begin errors++; $display("FAIL word_rd_lat: got %0d want 2", t_lat); end
      checks++; if (t_rd !== 64'h00000000_89ABCDEF) begin errors++; $display("FAIL word_rd_data: got %h want 0000000089abcdef", t_rd); end
      checks++; if (t_er !== 1'b0) begin errors++; $display("FAIL word_rd_err: got %b want 0", t_er); end
      checks++; if (a0_wen !== 4'b0000) begin errors++; $display("FAIL word_rd_wen: got %b want 0000", a0_wen); end
   endtask

   task automatic test_subword;
      xact(1'b1, 2'd0, 19'h00016, 64'h5A);
      checks++; if (a0_wen !== 4'b0010) begin errors++; $display("FAIL byte_wr_wen: got %b want 0010", a0_wen); end
      checks++; if (a0_data !== 32'h5A5A5A5A) begin errors++; $display("FAIL byte_wr_data: got %h want 5a5a5a5a", a0_data); end
      checks++; if (mem[5] !== 32'h89AB5AEF) begin errors++; $display("FAIL byte_wr_mem: got %h want 89ab5aef", mem[5]); end
      xact(1'b0, 2'd1, 19'h00014, 64'h0);
      checks++; if (t_rd !== 64'hFFFFFFFF_FFFF89AB) begin errors++; $display("FAIL half_rd_sext: got %h want ffffffffffff89ab", t_rd); end
      xact(1'b0, 2'd0, 19'h00017, 64'h0);
      checks++; if (t_rd !== 64'h00000000_000000EF) begin errors++; $display("FAIL byte_rd_lane3: got %h want ef", t_rd); end
      xact(1'b1, 2'd1, 19'h00016, 64'h1234);
      checks++; if (a0_wen !== 4'b0011) begin errors++; $display("FAIL half_wr_wen: got %b want 0011", a0_wen); end
      checks++; if (a0_data !== 32'h12341234) begin errors++; $display("FAIL half_wr_data: got %h want 12341234", a0_data); end
      checks++; if (mem[5] !== 32'h89AB1234) begin errors++; $display("FAIL half_wr_mem: got %h want 89ab1234", mem[5]); end
      xact(1'b0, 2'd1, 19'h00016, 64'h0);
      checks++; if (t_rd !== 64'h00000000_00001234) begin errors++; $display("FAIL half_rd_pos: got %h want 1234", t_rd); end
      xact(1'b0, 2'd0, 19'h00014, 64'h0);
      checks++; if (t_rd !== 64'h00000000_00000089) begin errors++; $display("FAIL byte_rd_zext: got %h want 89", t_rd); end
   endtask

   task automatic test_dword;
      xact(1'b1, 2'd3, 19'h1FFF8, 64'h11223344_55667788);
      checks++; if (t_lat !== 3) begin errors++; $display("FAIL dw_wr_lat: got %0d want 3", t_lat); end
      checks++; if (a0_addr !== 17'h07FFE || a1_addr !== 17'h07FFF) begin errors++; $display("FAIL dw_wr_addr: got %h/%h want 07ffe/07fff", a0_addr, a1_addr); end
      checks++; if (a0_data !== 32'h11223344 || a1_data !== 32'h55667788) begin errors++; $display("FAIL dw_wr_data: got %h/%h want 11223344/55667788", a0_data, a1_data); end
      checks++; if (a1_wen !== 4'b1111) begin errors++; $display("FAIL dw_wr_wen1: got %b want 1111", a1_wen); end
      checks++; if (mem[17'h07FFE] !== 32'h11223344 || mem[17'h07FFF] !== 32'h55667788) begin errors++; $display("FAIL dw_wr_mem: got %h/%h want 11223344/55667788", mem[17'h07FFE], mem[17'h07FFF]); end
      xact(1'b0, 2'd3, 19'h1FFF8, 64'h0);
      checks++; if (t_lat !== 3) begin errors++; $display("FAIL dw_rd_lat: got %0d want 3", t_lat); end
      checks++; if (t_rd !== 64'h11223344_55667788) begin errors++; $display("FAIL dw_rd_data: got %h want 1122334455667788", t_rd); end
      xact(1'b1, 2'd3, 19'h7FFF8, 64'hCAFEF00D_DEADBEEF);
      checks++; if (a0_addr !== 17'h1FFFE || a1_addr !== 17'h1FFFF) begin errors++; $display("FAIL dw_top_addr: got %h/%h want 1fffe/1ffff", a0_addr, a1_addr); end
      xact(1'b0, 2'd3, 19'h7FFF8, 64'h0);
      checks++; if (t_rd !== 64'hCAFEF00D_DEADBEEF) begin errors++; $display("FAIL dw_top_rd: got %h want cafef00ddeadbeef", t_rd); end
   endtask

   task automatic test_misalign;
      wen_seen = 1'b0;
      xact(1'b0, 2'd2, 19'h00015, 64'h0);
      checks++; if (t_lat !== 1) begin errors++; $display("FAIL mis_lat: got %0d want 1", t_lat); end
      checks++; if (t_er !== 1'b1) begin errors++; $display("FAIL mis_err: got %b want 1", t_er); end
      checks++; if (t_rd !== 64'h0) begin errors++; $display("FAIL mis_rdata: got %h want 0", t_rd); end
      xact(1'b1, 2'd2, 19'h00015, 64'hFFFF_FFFF);
      checks++; if (wen_seen !== 1'b0) begin errors++; $display("FAIL mis_no_write: wen activity %b want 0", wen_seen); end
      checks++; if (mem[5] !== 32'h89AB1234) begin errors++; $display("FAIL mis_mem: got %h want 89ab1234", mem[5]); end
      xact(1'b0, 2'd1, 19'h00015, 64'h0);
      checks++; if (t_er !== 1'b1) begin errors++; $display("FAIL mis_half_err: got %b want 1", t_er); end
      xact(1'b0, 2'd3, 19'h0001C, 64'h0);
      checks++; if (t_er !== 1'b1) begin errors++; $display("FAIL mis_dw_err: got %b want 1", t_er); end
      xact(1'b0, 2'd0, 19'h00015, 64'h0);
      checks++; if (t_er !== 1'b0 || t_rd !== 64'h00000000_000000AB) begin errors++; $display("FAIL byte_any_lane: err %b data %h want 0 / ab", t_er, t_rd); end
      n_xact(1'b0, 2'd2, 19'h00015);
      checks++; if (t_lat !== 2) begin errors++; $display("FAIL nochk_lat: got %0d want 2", t_lat); end
      checks++; if (a0_addr !== 17'h00005) begin errors++; $display("FAIL nochk_addr: got %h want 00005", a0_addr); end
      checks++; if (t_er !== 1'b0 || t_rd !== 64'h00000000_89ABCDEF) begin errors++; $display("FAIL nochk_data: err %b data %h want 0 / 89abcdef", t_er, t_rd); end
      checks++; if (n_mem_write_en !== 4'b0000 || n_mem_data_out !== 32'h0) begin errors++; $display("FAIL nochk_idle_wr: wen %b data %h want 0", n_mem_write_en, n_mem_data_out); end
   endtask

   task automatic test_reset_mid;
      int seen;
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_addr = 19'h1FFF8;
      req_wdata = 64'hAAAAAAAA_BBBBBBBB;
      @(posedge clock); #1;
      req_valid = 1'b0;
      checks++; if (mem_write_en !== 4'b1111) begin errors++; $display("FAIL mid_acc0_wen: got %b want 1111", mem_write_en); end
      #1 reset = 1'b0;
      #1;
      checks++; if (mem_write_en !== 4'b0000) begin errors++; $display("FAIL mid_wen_drop: got %b want 0000", mem_write_en); end
      seen = 0;
      repeat (3) begin @(posedge clock); #1; if (rsp_valid) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_rsp: rsp_valid cycles %0d want 0", seen); end
      checks++; if (mem[17'h07FFE] !== 32'h11223344 || mem[17'h07FFF] !== 32'h55667788) begin errors++; $display("FAIL mid_mem: got %h/%h want 11223344/55667788", mem[17'h07FFE], mem[17'h07FFF]); end
      @(negedge clock);
      reset = 1'b1;
      xact(1'b0, 2'd2, 19'h00014, 64'h0);
      checks++; if (t_lat !== 2 || t_rd !== 64'h00000000_89AB1234) begin errors++; $display("FAIL mid_next_req: lat %0d data %h want 2 / 89ab1234", t_lat, t_rd); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_word;
      test_subword;
      test_dword;
      test_misalign;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/memory_port.md
Name: memory_port

Overview:
- CPU-side memory access stage. It sits between the CPU core and the byte-lane word memory: 32-bit word, 17-bit word address, combinational read, synchronous write, 4 lane write enables, bit 0 = MSB.
- Accepts one byte/halfword/word/doubleword read or write request at a time from the core. Drives word address, lane enables and aligned data to memory. Returns right-justified read data or a write acknowledge.
- Doubleword accesses are split into two sequential word accesses.

Parameters:
- ALIGN_CHECK, 1: 1 = a misaligned request returns an error and does not touch memory; 0 = the low address bits below the natural alignment are ignored.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write, 0 = read
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = doubleword
- req_addr  in  19  byte address [0:18]; [0:16] word address, [17:18] byte lane
- req_wdata  in  64  write data, right-justified ([56:63] byte, [48:63] half, [32:63] word, [0:63] dword)
- rsp_valid  out  1  one-cycle response pulse
- rsp_error  out  1  misalignment flag, valid with rsp_valid
- rsp_rdata  out  64  read data, valid with rsp_valid when read and no error
- mem_address  out  17  word address to memory
- mem_write_en  out  4  lane enables, [0] = bits 0:7
- mem_data_out  out  32  write data to memory
- mem_data_in  in  32  memory read data (combinational)

Behaviour:
- States: IDLE, ACC0, ACC1, RESP.
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - req_ready=1; rsp_valid=0; rsp_error=0; rsp_rdata=0; mem_address=0; mem_write_en=0; mem_data_out=0.
  - A reset mid-access drops mem_write_en to 0 immediately. No response is issued.
- req_ready=1 only in IDLE. Accept = req_valid & req_ready at a rising edge. At accept, latch write, size, addr and wdata.
- Misalignment definition: half with addr[18]=1; word with addr[17:18]!=0; dword with addr[17:18]!=0 or addr[16]=1.
- Misaligned request with ALIGN_CHECK=1: IDLE -> RESP directly; rsp_error=1; rsp_rdata=0; no memory cycle.
- Otherwise IDLE -> ACC0. In ACC0, mem_address = latched addr[0:16].
  - Read: rsp_rdata is captured from mem_data_in at the end of ACC0.
    - byte: lane selected by addr[17:18], zero-extended to 64 bits.
    - half: lanes 0-1 if addr[17]=0, else lanes 2-3; sign-extended to 64 bits.
    - word: zero-extended into [32:63].
    - dword: ACC0 word goes into [0:31].
  - Write: mem_write_en and mem_data_out are asserted during ACC0 only; memory commits at the ACC0->next edge.
    - byte: the byte is replicated on all lanes; only lane addr[17:18] is enabled.
    - half: the halfword is replicated in both halves; enable 1100 or 0011.
    - word: enable 1111, data wdata[32:63].
    - dword: enable 1111, data wdata[0:31].
- dword: ACC0 -> ACC1.
  - ACC1 uses mem_address = addr[0:16] + 1, wrapping modulo 2^17 (1FFFF -> 00000).
  - Read: ACC1 word goes into [32:63]. Write: ACC1 writes wdata[32:63].
- Non-dword: ACC0 -> RESP.
- RESP: rsp_valid=1 for exactly one cycle; rsp_error is valid; then -> IDLE.
  - rsp_rdata holds its value until the next read response.
  - Write responses leave rsp_rdata unchanged. The core is always ready for a response; there is no backpressure.
- Latency from the accepting edge to rsp_valid high:
  - 2 edges for byte/half/word.
  - 3 edges for dword.
  - 1 edge for an error response.
- mem_write_en = 0 in IDLE and RESP. mem_address holds its last value in IDLE and RESP.
- Requests presented while req_ready=0 are ignored. The requester must hold req_valid and its request fields until acceptance.
- Writes never modify lanes outside the addressed ones.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req_valid=1 -> req_ready=1, mem_write_en=0, rsp_valid never asserts. Release -> request is accepted on the first edge.
- Word read:
  - Setup: memory word 0x05 = 0x89ABCDEF; read size=2, addr=0x14.
  - Required: mem_address=0x05 during ACC0; rsp_valid 2 edges after accept; rsp_rdata=0x00000000_89ABCDEF; rsp_error=0.
- Subword:
  - Byte write 0x5A to addr 0x16 -> mem_write_en=0010, word 0x05 becomes 0x89AB5AEF.
  - Halfword read at addr 0x14 -> rsp_rdata=0xFFFFFFFF_FFFF89AB.
  - Byte read at 0x17 -> 0x00000000_000000EF.
- Doubleword write and read:
  - Write 0x11223344_55667788 at addr 0x1FFF8 -> words 0x7FFE=0x11223344, 0x7FFF=0x55667788.
  - Dword write at byte address 0x7FFF8 (word 0x1FFFE) -> ACC1 address 0x1FFFF. With word address 0x1FFFF the second access wraps to 0x00000.
  - Read-back gives the identical 64-bit value; rsp_valid 3 edges after accept.
- Misalignment:
  - ALIGN_CHECK=1, word read at addr 0x15 -> rsp_valid 1 edge after accept, rsp_error=1, rsp_rdata=0, no mem_write_en activity.
  - ALIGN_CHECK=0, same request -> word 0x05 is returned, rsp_error=0.
- Reset mid-dword-write: assert reset during ACC0 -> mem_write_en falls to 0 without waiting for an edge, second word is untouched, no rsp_valid, next request is accepted normally.
